onewire_master_tx: RTL and testbench



---
 rtl/onewire_master_tx.sv | 199 +++++++++++++++++++
 tb/tb_onewire_master_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/onewire_master_tx.sv
// 1-Wire master transmitter: CRC-8 over a 56-bit command, bus reset with presence
// detect, then 64 MSB-first write slots of {command, crc} on an open-drain line.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | bus released, waiting for i_start
// S_CRC       | bit-serial CRC-8 (0x07) over cmd[55]..cmd[0], one bit/cycle
// S_RST_LOW   | bus driven low for T_RESET cycles
// S_PRES_WAIT | bus released, sampling for the slave presence pulse
// S_PRES_END  | wait for the bus to return high, then T_REC released cycles
// S_SLOT_LOW  | bus low for T_LOW1 (bit 1) or T_LOW0 (bit 0)
// S_SLOT_REL  | bus released until T_SLOT cycles since the slot began
// S_REC       | bus released for T_REC, then next bit or done
module onewire_master_tx #(
   parameter int T_RESET = 480,
   parameter int T_PWAIT = 240,
   parameter int T_SLOT  = 70,
   parameter int T_LOW1  = 6,
   parameter int T_LOW0  = 60,
   parameter int T_REC   = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [55:0] i_command,
   input  logic        i_start,
   inout  wire         bus,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_no_presence,
   output logic [7:0]  o_crc
);

   localparam int CW = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_CRC, S_RST_LOW, S_PRES_WAIT, S_PRES_END, S_SLOT_LOW, S_SLOT_REL, S_REC
   } state_t;

   state_t         state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [5:0]     idx, idx_n, nxt_idx;
   logic [55:0]    cmd, cmd_n;
   logic [7:0]     crc, crc_n, crc_step, ocrc_n;
   logic [63:0]    frame, frame_n;
   logic           pres_seen, pres_n, pres_now;
   logic           done_r, done_n, nopres_n;
   logic           drive_low, drive_n;
   logic           bus_m, bus_s;
   logic           fb;
   logic [CW-1:0]  cur_low, nxt_low;

   assign bus = drive_low ? 1'b0 : 1'bz;

   assign fb       = crc[7] ^ cmd[cnt[5:0]];
   assign crc_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   assign nxt_idx  = (state == S_REC) ? idx - 6'd1 : 6'd63;
   assign cur_low  = frame[idx]     ? CW'(T_LOW1) : CW'(T_LOW0);
   assign nxt_low  = frame[nxt_idx] ? CW'(T_LOW1) : CW'(T_LOW0);
   assign o_busy   = (state != S_IDLE) && !o_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         idx           <= '0;
         cmd           <= '0;
         crc           <= '0;
         frame         <= '0;
         o_crc         <= '0;
         o_no_presence <= 1'b0;
         pres_seen     <= 1'b0;
         done_r        <= 1'b0;
         drive_low     <= 1'b0;
         bus_m         <= 1'b1;
         bus_s         <= 1'b1;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         idx           <= idx_n;
         cmd           <= cmd_n;
         crc           <= crc_n;
         frame         <= frame_n;
         o_crc         <= ocrc_n;
         o_no_presence <= nopres_n;
         pres_seen     <= pres_n;
         done_r        <= done_n;
         drive_low     <= drive_n;
         bus_m         <= bus;
         bus_s         <= bus_m;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = idx;
      cmd_n    = cmd;
      crc_n    = crc;
      frame_n  = frame;
      ocrc_n   = o_crc;
      pres_n   = pres_seen;
      pres_now = 1'b0;
      nopres_n = o_no_presence;
      done_n   = 1'b0;
      o_done   = done_r;
      case (state)
         S_IDLE: begin
            if (i_start && !done_r) begin
               cmd_n    = i_command;
               nopres_n = 1'b0;
               crc_n    = '0;
               cnt_n    = CW'(55);
               state_n  = S_CRC;
            end
         end
         S_CRC: begin
            crc_n = crc_step;
            if (cnt == '0) begin
               ocrc_n  = crc_step;
               frame_n = {cmd, crc_step};
               cnt_n   = CW'(T_RESET - 1);
               state_n = S_RST_LOW;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         S_RST_LOW: begin
            if (cnt == '0) begin
               cnt_n   = CW'(T_PWAIT);
               pres_n  = 1'b0;
               state_n = S_PRES_WAIT;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         S_PRES_WAIT: begin
            // The first two synchronized samples still carry our own reset pulse.
            pres_now = pres_seen || (!bus_s && (cnt <= CW'(T_PWAIT - 2)));
            pres_n   = pres_now;
            if (cnt == '0) begin
               if (pres_now) begin
                  cnt_n   = CW'(T_REC - 1);
                  state_n = S_PRES_END;
               end else begin
                  nopres_n = 1'b1;
                  done_n   = 1'b1;
                  state_n  = S_IDLE;
               end
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         S_PRES_END: begin
            if (!bus_s) begin
               cnt_n = CW'(T_REC - 1);
            end else if (cnt == '0) begin
               idx_n   = nxt_idx;
               cnt_n   = nxt_low - CW'(1);
               state_n = S_SLOT_LOW;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         S_SLOT_LOW: begin
            if (cnt == '0) begin
               cnt_n   = CW'(T_SLOT) - cur_low - CW'(1);
               state_n = S_SLOT_REL;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         S_SLOT_REL: begin
            if (cnt == '0) begin
               cnt_n   = CW'(T_REC - 1);
               state_n = S_REC;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         S_REC: begin
            if (cnt == '0) begin
               if (idx == 6'd0) begin
                  o_done  = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  idx_n   = nxt_idx;
                  cnt_n   = nxt_low - CW'(1);
                  state_n = S_SLOT_LOW;
               end
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase
      drive_n = (state_n == S_RST_LOW) || (state_n == S_SLOT_LOW);
   end

endmodule

// File: tb/tb_onewire_master_tx.sv
// Directed bench for onewire_master_tx: presence-answering slave model, slot-width
// decoder standing in for the slave receive path, no-slave and mid-slot reset cases.
module tb_onewire_master_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [55:0] i_command = '0;
   logic        i_start = 1'b0;
   wire         bus;
   logic        o_busy, o_done, o_no_presence;
   logic [7:0]  o_crc;

   int errors = 0;
   int checks = 0;

   logic slave_en = 1'b0;
   int   low_run = 0, slave_pend = 0, slave_hold = 0;

   logic        dec_clr = 1'b1;
   int          low_w = 0, dec_n = 0, dec_bad_w = 0;
   logic [63:0] dec_frame = '0;

   pullup (bus);
   assign bus = (slave_hold != 0) ? 1'b0 : 1'bz;

   onewire_master_tx dut (
      .clk(clk), .reset(reset), .i_command(i_command), .i_start(i_start), .bus(bus),
      .o_busy(o_busy), .o_done(o_done), .o_no_presence(o_no_presence), .o_crc(o_crc)
   );

   always #5 clk = ~clk;

   // Slave: after a long low (bus reset) goes high, wait 20 cycles then pull low for 100.
   always @(posedge clk) begin
      if (slave_pend > 0) begin
         slave_pend <= slave_pend - 1;
         if (slave_pend == 1) slave_hold <= 100;
      end else if (slave_hold > 0) begin
         slave_hold <= slave_hold - 1;
      end
      if (!bus && slave_hold == 0) begin
         low_run <= low_run + 1;
      end else begin
         if (slave_en && low_run >= 400) slave_pend <= 20;
         low_run <= 0;
      end
   end

   // Slave receive path: low widths up to one slot are bits; short low means 1.
   always @(posedge clk) begin
      if (dec_clr) begin
         low_w <= 0; dec_n <= 0; dec_bad_w <= 0; dec_frame <= '0;
      end else if (!bus) begin
         low_w <= low_w + 1;
      end else begin
         if (low_w > 0 && low_w <= 70) begin
            dec_frame <= {dec_frame[62:0], (low_w < 30)};
            dec_n     <= dec_n + 1;
            if (low_w != 6 && low_w != 60) dec_bad_w <= dec_bad_w + 1;
         end
         low_w <= 0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] crc8(input logic [55:0] c);
      logic [7:0] r = 8'h00;
      for (int i = 55; i >= 0; i--) begin
         if (r[7] ^ c[i]) r = {r[6:0], 1'b0} ^ 8'h07;
         else             r = {r[6:0], 1'b0};
      end
      return r;
   endfunction

   // Returns at cycle 1 relative to the cycle i_start is sampled.
   task automatic start(input logic [55:0] c);
      i_command = c;
      i_start   = 1'b1;
      tick(1);
      i_start   = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output int took);
      took = -1;
      for (int i = 0; i < maxc; i++) begin
         if (o_done) begin
            took = i;
            break;
         end
         tick(1);
      end
   endtask

   task automatic run_xfer(input string tag, input logic [55:0] c, input logic [7:0] exp_crc,
                           input logic poke_busy);
      int t;
      dec_clr = 1'b1;
      tick(1);
      dec_clr  = 1'b0;
      slave_en = 1'b1;
      start(c);
      chk({tag, "_busy_c1"}, 64'(o_busy), 64'd1);
      chk({tag, "_nopres_clr"}, 64'(o_no_presence), 64'd0);
      if (poke_busy) begin
         tick(9);
         i_command = 56'hABCDEF;
         i_start   = 1'b1;
         tick(1);
         i_start   = 1'b0;
         chk({tag, "_busy_after_poke"}, 64'(o_busy), 64'd1);
         tick(46);
      end else begin
         tick(56);
      end
      chk({tag, "_crc_c57"}, 64'(o_crc), 64'(exp_crc));
      chk({tag, "_bus_low_c57"}, 64'(bus), 64'd0);
      tick(479);
      chk({tag, "_bus_low_c536"}, 64'(bus), 64'd0);
      tick(1);
      chk({tag, "_bus_rel_c537"}, 64'(bus), 64'd1);
      wait_done(7000, t);
      chk({tag, "_done_seen"}, 64'(t >= 0), 64'd1);
      chk({tag, "_busy_at_done"}, 64'(o_busy), 64'd0);
      chk({tag, "_nopres"}, 64'(o_no_presence), 64'd0);
      chk({tag, "_slots"}, 64'(dec_n), 64'd64);
      chk({tag, "_frame"}, dec_frame, {c, exp_crc});
      chk({tag, "_slot_widths_bad"}, 64'(dec_bad_w), 64'd0);
      tick(1);
      chk({tag, "_done_pulse"}, 64'(o_done), 64'd0);
   endtask

   initial begin
      int t;
      int lows;
      tick(1);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      chk("rst_nopres", 64'(o_no_presence), 64'd0);
      chk("rst_crc", 64'(o_crc), 64'd0);
      chk("rst_bus", 64'(bus), 64'd1);
      tick(2);
      reset = 1'b0;
      tick(2);

      run_xfer("t1_zero", 56'h0, 8'h00, 1'b1);
      run_xfer("t2_one", 56'h1, 8'h07, 1'b0);
      run_xfer("t3_ff", 56'hFF, 8'hF3, 1'b0);
      chk("t3_slave_cmd", 64'(dec_frame[63:8]), 64'hFF);
      chk("t3_slave_err", 64'(crc8(dec_frame[63:8]) != dec_frame[7:0]), 64'd0);
      chk("model_crc_a5", 64'(crc8(56'h0123456789ABCD)), 64'(crc8(56'h0123456789ABCD)) ^ 64'd0);

      // No slave: presence window expires, done one cycle after the decision.
      slave_en = 1'b0;
      tick(5);
      start(56'h1234);
      tick(56);
      chk("t4_bus_low_c57", 64'(bus), 64'd0);
      tick(479);
      chk("t4_bus_low_c536", 64'(bus), 64'd0);
      tick(1);
      chk("t4_bus_rel_c537", 64'(bus), 64'd1);
      tick(240);
      chk("t4_done_c777", 64'(o_done), 64'd0);
      chk("t4_busy_c777", 64'(o_busy), 64'd1);
      tick(1);
      chk("t4_done_c778", 64'(o_done), 64'd1);
      chk("t4_nopres_c778", 64'(o_no_presence), 64'd1);
      chk("t4_busy_c778", 64'(o_busy), 64'd0);
      lows = 0;
      repeat (200) begin
         tick(1);
         if (!bus) lows++;
      end
      chk("t4_no_slots", 64'(lows), 64'd0);
      chk("t4_nopres_hold", 64'(o_no_presence), 64'd1);

      // Reset asserted while a slot is driving the bus low.
      dec_clr = 1'b1;
      tick(1);
      dec_clr  = 1'b0;
      slave_en = 1'b1;
      start(56'hFF);
      chk("t5_nopres_clr", 64'(o_no_presence), 64'd0);
      t = -1;
      for (int i = 0; i < 3000; i++) begin
         if (dec_n >= 3) begin
            t = i;
            break;
         end
         tick(1);
      end
      chk("t5_slots_started", 64'(t >= 0), 64'd1);
      t = -1;
      for (int i = 0; i < 200; i++) begin
         if (!bus) begin
            t = i;
            break;
         end
         tick(1);
      end
      chk("t5_slot_low_seen", 64'(t >= 0), 64'd1);
      chk("t5_crc_before_rst", 64'(o_crc), 64'hF3);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_bus_rel_now", 64'(bus), 64'd1);
      chk("t5_busy_rst", 64'(o_busy), 64'd0);
      chk("t5_done_rst", 64'(o_done), 64'd0);
      chk("t5_nopres_rst", 64'(o_no_presence), 64'd0);
      chk("t5_crc_rst", 64'(o_crc), 64'd0);
      tick(2);
      reset = 1'b0;
      tick(2);
      run_xfer("t6_after_rst", 56'h1, 8'h07, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
